// File: rtl/bombe_result_queue.sv
`default_nettype none
// ============================================================================
// Module      : bombe_result_queue
// Description : First-word-fall-through queue that buffers rotor "hits" from
//               the Bombe search stage and hands them to a consumer.
//               Each entry is {rotor_select, rotor_initial} (24 bits).
//               A hit arriving when the queue is full, with no pop in that
//               cycle, is dropped and recorded in a sticky overflow flag. A
//               saturating counter tallies every accepted hit, whether it is
//               stored or dropped. After search_done_in the queue stops
//               accepting hits and flushes. drained_out rises once every
//               stored hit has been delivered.
// Ports       :
//   clk_in             - single clock, rising edge
//   rst_in             - synchronous active-high reset
//   rotor_select_in    - three 3-bit rotor numbers of a hit
//   rotor_initial_in   - three 5-bit rotor start positions of a hit
//   rotor_valid_in     - one-cycle hit qualifier, no backpressure
//   search_done_in     - search finished (level or pulse)
//   result_select_out  - rotor numbers of the head entry
//   result_initial_out - start positions of the head entry
//   result_valid_out   - head entry present
//   result_ready_in    - consumer accepts the head entry
//   hit_count_out      - saturating total of hits seen
//   overflow_out       - sticky, at least one hit dropped
//   drained_out        - search done and queue fully delivered
// Revision    : 1.0 - initial release
// ============================================================================
module bombe_result_queue #(
    parameter int DEPTH = 16
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [8:0]  rotor_select_in,
    input  logic [14:0] rotor_initial_in,
    input  logic        rotor_valid_in,
    input  logic        search_done_in,
    output logic [8:0]  result_select_out,
    output logic [14:0] result_initial_out,
    output logic        result_valid_out,
    input  logic        result_ready_in,
    output logic [15:0] hit_count_out,
    output logic        overflow_out,
    output logic        drained_out
);

    localparam int             c_AW   = $clog2(DEPTH);
    localparam logic [c_AW:0]  c_FULL = DEPTH[c_AW:0];

    typedef enum logic [1:0] {
        S_COLLECT = 2'd0,
        S_FLUSH   = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_next;

    logic [23:0]     r_mem [DEPTH];
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_AW:0]   r_count;
    logic [c_AW:0]   w_count_next;
    logic [15:0]     r_hit_count;
    logic            r_overflow;

    logic            w_push;
    logic            w_pop;
    logic            w_write;
    logic            w_drop;

    // Hits are only accepted while collecting.
    assign w_push  = rotor_valid_in && (r_state == S_COLLECT);
    assign w_pop   = (r_count != '0) && result_ready_in;
    // A simultaneous pop frees a slot, so a full queue can still take a hit.
    assign w_write = w_push && ((r_count != c_FULL) || w_pop);
    assign w_drop  = w_push && (r_count == c_FULL) && !w_pop;

    always_comb begin
        w_count_next = r_count;
        if (w_write && !w_pop) begin
            w_count_next = r_count + 1'b1;
        end else if (!w_write && w_pop) begin
            w_count_next = r_count - 1'b1;
        end
    end

    // Next-state logic. The FLUSH exit uses the post-pop count so the final
    // pop and the move to DONE land on the same edge.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_COLLECT: if (search_done_in)        w_state_next = S_FLUSH;
            S_FLUSH:   if (w_count_next == '0)    w_state_next = S_DONE;
            S_DONE:                               w_state_next = S_DONE;
            default:                              w_state_next = S_COLLECT;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state     <= S_COLLECT;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_hit_count <= '0;
            r_overflow  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_count <= w_count_next;
            if (w_write) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && (r_hit_count != 16'hFFFF)) begin
                r_hit_count <= r_hit_count + 16'd1;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Storage has no reset; pointers and count define what is valid.
    always_ff @(posedge clk_in) begin
        if (w_write && !rst_in) begin
            r_mem[r_wr_ptr] <= {rotor_select_in, rotor_initial_in};
        end
    end

    assign result_valid_out   = (r_count != '0);
    assign result_select_out  = r_mem[r_rd_ptr][23:15];
    assign result_initial_out = r_mem[r_rd_ptr][14:0];
    assign hit_count_out      = r_hit_count;
    assign overflow_out       = r_overflow;
    assign drained_out        = (r_state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_bombe_result_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_bombe_result_queue
// Description : Self-checking bench for bombe_result_queue (DEPTH = 16).
//               Directed scenarios plus randomized traffic are compared
//               against a queue-based behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bombe_result_queue;

    localparam int DEPTH = 16;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic [8:0]  rotor_select_in;
    logic [14:0] rotor_initial_in;
    logic        rotor_valid_in;
    logic        search_done_in;
    logic [8:0]  result_select_out;
    logic [14:0] result_initial_out;
    logic        result_valid_out;
    logic        result_ready_in;
    logic [15:0] hit_count_out;
    logic        overflow_out;
    logic        drained_out;

    bombe_result_queue #(.DEPTH(DEPTH)) dut (
        .clk_in             (clk_in),
        .rst_in             (rst_in),
        .rotor_select_in    (rotor_select_in),
        .rotor_initial_in   (rotor_initial_in),
        .rotor_valid_in     (rotor_valid_in),
        .search_done_in     (search_done_in),
        .result_select_out  (result_select_out),
        .result_initial_out (result_initial_out),
        .result_valid_out   (result_valid_out),
        .result_ready_in    (result_ready_in),
        .hit_count_out      (hit_count_out),
        .overflow_out       (overflow_out),
        .drained_out        (drained_out)
    );

    always #5 clk_in = ~clk_in;

    int n_total = 0;
    int n_bad   = 0;

    // Reference model: a plain queue plus phase (0 collect, 1 flush, 2 done).
    logic [23:0] m_q[$];
    int          m_hits;
    logic        m_ovf;
    int          m_phase;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_outputs();
        chk("valid", 32'(result_valid_out), 32'(m_q.size() != 0));
        if (m_q.size() != 0 && result_valid_out === 1'b1) begin
            chk("data", 32'({result_select_out, result_initial_out}), 32'(m_q[0]));
        end
        chk("hits", 32'(hit_count_out), m_hits);
        chk("ovf", 32'(overflow_out), 32'(m_ovf));
        chk("drained", 32'(drained_out), 32'(m_phase == 2));
    endtask

    task automatic model_step(input logic v, input logic [23:0] d, input logic done,
                              input logic rdy, input logic rs);
        if (rs) begin
            m_q.delete();
            m_hits  = 0;
            m_ovf   = 1'b0;
            m_phase = 0;
        end else begin
            bit was_collect;
            was_collect = (m_phase == 0);
            if (m_q.size() != 0 && rdy) void'(m_q.pop_front());
            if (v && was_collect) begin
                if (m_hits < 65535) m_hits++;
                if (m_q.size() < DEPTH) m_q.push_back(d);
                else m_ovf = 1'b1;
            end
            if (was_collect) begin
                if (done) m_phase = 1;
            end else if (m_phase == 1 && m_q.size() == 0) begin
                m_phase = 2;
            end
        end
    endtask

    // One clock cycle: drive inputs, check at the falling edge, advance model.
    task automatic cyc(input logic v, input logic [8:0] s, input logic [14:0] i,
                       input logic done, input logic rdy, input logic rs);
        rotor_valid_in   = v;
        rotor_select_in  = s;
        rotor_initial_in = i;
        search_done_in   = done;
        result_ready_in  = rdy;
        rst_in           = rs;
        @(negedge clk_in);
        check_outputs();
        model_step(v, {s, i}, done, rdy, rs);
        @(posedge clk_in);
        #1;
    endtask

    task automatic rand_hit(input logic done, input logic rdy);
        logic [8:0]  s;
        logic [14:0] i;
        s = 9'($urandom_range(511));
        i = 15'($urandom_range(32767));
        cyc(1'b1, s, i, done, rdy, 1'b0);
    endtask

    task automatic idle(input logic rdy, input int n);
        for (int k = 0; k < n; k++) cyc(1'b0, 9'd0, 15'd0, 1'b0, rdy, 1'b0);
    endtask

    task automatic do_reset();
        cyc(1'b0, 9'd0, 15'd0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        rst_in           = 1'b1;
        rotor_valid_in   = 1'b0;
        rotor_select_in  = '0;
        rotor_initial_in = '0;
        search_done_in   = 1'b0;
        result_ready_in  = 1'b0;
        // Initial reset: outputs are unknown before it, so nothing is checked.
        @(posedge clk_in);
        #1;
        model_step(1'b0, 24'd0, 1'b0, 1'b0, 1'b1);

        // Three hits with ready held high, delivered in order.
        cyc(1'b1, 9'h041, 15'h0421, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 9'h083, 15'h1842, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 9'h10A, 15'h7FFF, 1'b0, 1'b1, 1'b0);
        idle(1'b1, 3);
        chk("seq3_hits", 32'(hit_count_out), 32'd3);
        chk("seq3_ovf", 32'(overflow_out), 32'd0);

        // Twenty hits into a depth-16 queue with ready low: four dropped.
        do_reset();
        for (int k = 0; k < 20; k++) rand_hit(1'b0, 1'b0);
        chk("ovf20_hits", 32'(hit_count_out), 32'd20);
        chk("ovf20_ovf", 32'(overflow_out), 32'd1);
        idle(1'b1, 18);
        chk("ovf20_empty", 32'(result_valid_out), 32'd0);

        // Full queue, push and pop together: entry stored, no overflow.
        do_reset();
        for (int k = 0; k < DEPTH; k++) rand_hit(1'b0, 1'b0);
        rand_hit(1'b0, 1'b1);
        chk("full_pp_ovf", 32'(overflow_out), 32'd0);
        idle(1'b1, DEPTH + 1);

        // Five hits, done pulse, later hits ignored, then drain.
        do_reset();
        for (int k = 0; k < 5; k++) rand_hit(1'b0, 1'b0);
        cyc(1'b0, 9'd0, 15'd0, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) rand_hit(1'b0, 1'b0);
        idle(1'b1, 6);
        chk("flush_hits", 32'(hit_count_out), 32'd5);
        chk("flush_drained", 32'(drained_out), 32'd1);

        // Randomized traffic with a reset at the start of each segment.
        for (int seg = 0; seg < 20; seg++) begin
            int pv;
            int pr;
            do_reset();
            pv = $urandom_range(100);
            pr = $urandom_range(100);
            for (int k = 0; k < 200; k++) begin
                logic v;
                logic r;
                logic d;
                v = ($urandom_range(99) < pv);
                r = ($urandom_range(99) < pr);
                d = ($urandom_range(199) == 0);
                if (v) rand_hit(d, r);
                else cyc(1'b0, 9'd0, 15'd0, d, r, 1'b0);
            end
        end

        // Reset mid-operation with 7 entries held and overflow set.
        do_reset();
        for (int k = 0; k < DEPTH + 1; k++) rand_hit(1'b0, 1'b0);
        idle(1'b1, 9);
        chk("pre_rst_ovf", 32'(overflow_out), 32'd1);
        chk("pre_rst_valid", 32'(result_valid_out), 32'd1);
        // Push and pop presented in the reset cycle must be ignored.
        cyc(1'b1, 9'h1FF, 15'h1234, 1'b0, 1'b1, 1'b1);
        chk("rst_valid", 32'(result_valid_out), 32'd0);
        chk("rst_hits", 32'(hit_count_out), 32'd0);
        chk("rst_ovf", 32'(overflow_out), 32'd0);
        chk("rst_drained", 32'(drained_out), 32'd0);
        // Still collecting after reset: a hit is accepted.
        rand_hit(1'b0, 1'b0);
        chk("rst_collect", 32'(result_valid_out), 32'd1);

        // Hit counter saturation.
        do_reset();
        for (int k = 0; k < 70000; k++) rand_hit(1'b0, 1'b1);
        idle(1'b1, 2);
        chk("sat_hits", 32'(hit_count_out), 32'hFFFF);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
